// File: rtl/zap_booth_pkg.sv
// rtl/zap_booth_pkg.sv - shared constants for the radix-4 Booth long multiply-accumulate unit
package zap_booth_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int NUM_DIGITS = 17;
  localparam int COUNT_W    = 5;

  // Long-multiply opcode field values (instruction bits [24:21])
  localparam logic [3:0] OP_UMULL = 4'b0100;
  localparam logic [3:0] OP_UMLAL = 4'b0101;
  localparam logic [3:0] OP_SMULL = 4'b0110;
  localparam logic [3:0] OP_SMLAL = 4'b0111;

  function automatic logic [63:0] extend_operand(input logic [31:0] value, input logic is_signed);
    return {{32{is_signed & value[31]}}, value};
  endfunction

endpackage

// File: rtl/zap_booth_digit.sv
// rtl/zap_booth_digit.sv - selects the Booth partial product (0, +-M, +-2M) from a 3-bit window
module zap_booth_digit (
  input  logic [2:0]  window,
  input  logic [63:0] m,
  output logic [63:0] pp
);

  always_comb begin
    pp = 64'd0;
    case (window)
      3'b001, 3'b010: pp = m;
      3'b011:         pp = m << 1;
      3'b100:         pp = -(m << 1);
      3'b101, 3'b110: pp = -m;
      default:        pp = 64'd0;
    endcase
  end

endmodule

// File: rtl/zap_booth_mac.sv
// rtl/zap_booth_mac.sv - iterative radix-4 Booth 32x32+64 multiply-accumulate with half-word result cache
module zap_booth_mac
  import zap_booth_pkg::*;
#(
  parameter int CACHE_EN = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_signed,
  input  logic        i_high,
  input  logic        i_accumulate,
  input  logic [31:0] i_rm,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rn,
  input  logic [31:0] i_rh,
  input  logic        i_clear,
  output logic [31:0] o_rd,
  output logic        o_busy,
  output logic        o_nozero
);

  logic [1:0]         state;
  logic [COUNT_W-1:0] count;
  logic [63:0]        psum;
  logic [63:0]        cache_result;
  logic               cache_valid;

  // The latched operands double as the cache tag once the result is written.
  logic [31:0] rm_q, rs_q, rn_q, rh_q;
  logic        signed_q, accumulate_q, high_q;

  logic        tag_equal, hit, start_miss;
  logic [63:0] m_ext, acc_ext, pp;
  logic [34:0] y_ext;
  logic [2:0]  window;

  assign tag_equal = ({i_rm, i_rs, i_rn, i_rh, i_signed, i_accumulate} ==
                      {rm_q, rs_q, rn_q, rh_q, signed_q, accumulate_q});
  assign hit        = i_start & cache_valid & (CACHE_EN != 0) & tag_equal;
  assign start_miss = (state == S_IDLE) & i_start & ~hit;

  assign m_ext   = extend_operand(rm_q, signed_q);
  assign y_ext   = {{2{signed_q & rs_q[31]}}, rs_q, 1'b0};
  assign window  = y_ext[{count, 1'b0} +: 3];
  assign acc_ext = accumulate_q ? {rh_q, rn_q} : 64'd0;

  zap_booth_digit u_digit (
    .window (window),
    .m      (m_ext),
    .pp     (pp)
  );

  // Outputs are gated by reset so they read zero while reset is held, even mid-request.
  always_comb begin
    o_busy   = 1'b0;
    o_rd     = 32'd0;
    o_nozero = 1'b0;
    case (state)
      S_IDLE: begin
        if (hit) begin
          o_rd     = i_high ? cache_result[63:32] : cache_result[31:0];
          o_nozero = |cache_result;
        end else if (i_start) begin
          o_busy = 1'b1;
        end
      end
      S_ITER, S_ACC: o_busy = 1'b1;
      S_DONE: begin
        o_rd     = high_q ? cache_result[63:32] : cache_result[31:0];
        o_nozero = |cache_result;
      end
      default: o_busy = 1'b0;
    endcase
    if (!i_reset) begin
      o_busy   = 1'b0;
      o_rd     = 32'd0;
      o_nozero = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state        <= S_IDLE;
      count        <= '0;
      psum         <= 64'd0;
      cache_result <= 64'd0;
      cache_valid  <= 1'b0;
      rm_q         <= 32'd0;
      rs_q         <= 32'd0;
      rn_q         <= 32'd0;
      rh_q         <= 32'd0;
      signed_q     <= 1'b0;
      accumulate_q <= 1'b0;
      high_q       <= 1'b0;
    end else if (i_clear) begin
      state       <= S_IDLE;
      count       <= '0;
      cache_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_miss) begin
            rm_q         <= i_rm;
            rs_q         <= i_rs;
            rn_q         <= i_rn;
            rh_q         <= i_rh;
            signed_q     <= i_signed;
            accumulate_q <= i_accumulate;
            high_q       <= i_high;
            psum         <= 64'd0;
            count        <= '0;
            cache_valid  <= 1'b0;
            state        <= S_ITER;
          end
        end
        S_ITER: begin
          psum <= psum + (pp << {count, 1'b0});
          if (count == COUNT_W'(NUM_DIGITS - 1)) begin
            count <= '0;
            state <= S_ACC;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_ACC: begin
          cache_result <= psum + acc_ext;
          cache_valid  <= 1'b1;
          state        <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zap_booth_mac.sv
// tb/tb_zap_booth_mac.sv - directed self-checking bench for zap_booth_mac
module tb_zap_booth_mac;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic        i_signed;
  logic        i_high;
  logic        i_accumulate;
  logic [31:0] i_rm, i_rs, i_rn, i_rh;
  logic        i_clear;
  logic [31:0] o_rd;
  logic        o_busy;
  logic        o_nozero;

  int total  = 0;
  int passed = 0;

  always #5 i_clk = ~i_clk;

  zap_booth_mac #(.CACHE_EN(1)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_signed     (i_signed),
    .i_high       (i_high),
    .i_accumulate (i_accumulate),
    .i_rm         (i_rm),
    .i_rs         (i_rs),
    .i_rn         (i_rn),
    .i_rh         (i_rh),
    .i_clear      (i_clear),
    .o_rd         (o_rd),
    .o_busy       (o_busy),
    .o_nozero     (o_nozero)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_ops(input logic [31:0] rm, input logic [31:0] rs, input logic [31:0] rn,
                         input logic [31:0] rh, input logic sgn, input logic acc, input logic high);
    i_rm         = rm;
    i_rs         = rs;
    i_rn         = rn;
    i_rh         = rh;
    i_signed     = sgn;
    i_accumulate = acc;
    i_high       = high;
  endtask

  // Holds a request until busy drops, then checks stall length, result word and non-zero flag.
  task automatic mac(input string tag, input logic [31:0] rm, input logic [31:0] rs,
                     input logic [31:0] rn, input logic [31:0] rh, input logic sgn,
                     input logic acc, input logic high, input int exp_cycles,
                     input logic [31:0] exp_rd, input logic exp_nz);
    int n;
    set_ops(rm, rs, rn, rh, sgn, acc, high);
    i_start = 1'b1;
    #1;
    n = 0;
    while (o_busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    check({tag, " busy_cycles"}, 32'(n), 32'(exp_cycles));
    check({tag, " rd"}, o_rd, exp_rd);
    check({tag, " nozero"}, {31'd0, o_nozero}, {31'd0, exp_nz});
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    i_reset = 1'b0;
    i_start = 1'b0;
    i_clear = 1'b0;
    set_ops(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("reset busy", {31'd0, o_busy}, 32'd0);
    check("reset rd", o_rd, 32'd0);
    check("reset nozero", {31'd0, o_nozero}, 32'd0);
    tick();
    tick();
    i_reset = 1'b1;
    tick();

    set_ops(32'h1234_5678, 32'h9ABC_DEF0, 32'h1, 32'h2, 1'b1, 1'b1, 1'b1);
    #1;
    check("idle rd", o_rd, 32'd0);
    check("idle busy", {31'd0, o_busy}, 32'd0);
    tick();

    mac("umul_max_lo", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 19, 32'h0000_0001, 1'b1);
    mac("umul_max_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 0, 32'hFFFF_FFFE, 1'b1);

    mac("smlal_zero_lo", 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1, 1'b0, 19, 32'h0, 1'b0);
    mac("smlal_zero_hi", 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1, 1'b1, 0, 32'h0, 1'b0);

    mac("smul_min_hi", 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 19, 32'h4000_0000, 1'b1);
    mac("smul_min_lo", 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b1);

    mac("wrap_lo", 32'd2, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 19, 32'h0000_0005, 1'b1);
    mac("wrap_hi", 32'd2, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 0, 32'h0, 1'b1);

    mac("umul_neg1_hi", 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 19, 32'h0, 1'b1);
    mac("umul_neg1_lo", 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 0, 32'hFFFF_FFFF, 1'b1);

    // Clear while idle must drop the cached result.
    mac("pow32_hi", 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 19, 32'h1, 1'b1);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    mac("pow32_after_clear", 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 19, 32'h1, 1'b1);

    // Flush at digit 5, then the same request must recompute from scratch.
    set_ops(32'hFFFF_FFFD, 32'd7, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    i_start = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    check("iter5 busy", {31'd0, o_busy}, 32'd1);
    i_clear = 1'b1;
    i_start = 1'b0;
    tick();
    i_clear = 1'b0;
    #1;
    check("post_clear busy", {31'd0, o_busy}, 32'd0);
    check("post_clear rd", o_rd, 32'd0);
    tick();
    mac("sneg_lo", 32'hFFFF_FFFD, 32'd7, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 19, 32'hFFFF_FFEB, 1'b1);
    mac("sneg_hi", 32'hFFFF_FFFD, 32'd7, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 0, 32'hFFFF_FFFF, 1'b1);

    // Reset mid-iteration with the request still held.
    set_ops(32'd2, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    i_start = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    #2;
    i_reset = 1'b0;
    #1;
    check("reset_mid busy", {31'd0, o_busy}, 32'd0);
    check("reset_mid rd", o_rd, 32'd0);
    tick();
    tick();
    i_reset = 1'b1;
    mac("after_reset", 32'd2, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 19, 32'h6, 1'b1);
    mac("sneg_after_reset", 32'hFFFF_FFFD, 32'd7, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 19, 32'hFFFF_FFFF, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/zap_booth_mac.md
ZAP_BOOTH_MAC -- requirements
Module: zap_booth_mac

Interface
REQ-001 SHALL have parameter CACHE_EN, default 1, meaning: 1 enables the result cache for back-to-back low/high half requests.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port i_clk  input  1  rising-edge clock.
REQ-004 SHALL have port i_reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_start  input  1  multiply-accumulate request from the shift stage (long-multiply op with condition satisfied), held while o_busy=1.
REQ-006 SHALL have port i_signed  input  1  1 = signed (SMLAL*), 0 = unsigned (UMLAL*).
REQ-007 SHALL have port i_high  input  1  selects result word: 1 = bits[63:32], 0 = bits[31:0].
REQ-008 SHALL have port i_accumulate  input  1  1 = add {i_rh,i_rn}; 0 = accumulator treated as zero.
REQ-009 SHALL have ports i_rm, i_rs, i_rn, i_rh  input  32 each  multiplicand, multiplier, accumulator low, accumulator high.
REQ-010 SHALL have port i_clear  input  1  pipeline flush (writeback or ALU clear).
REQ-011 SHALL have port o_rd  output  32  selected result word.
REQ-012 SHALL have port o_busy  output  1  stall request to the shift stage.
REQ-013 SHALL have port o_nozero  output  1  full 64-bit result is non-zero.

Function
REQ-014 SHALL compute (i_rm × i_rs) + {i_rh,i_rn} modulo 2^64; operands sign-extended to 34 bits when i_signed=1, zero-extended otherwise.
REQ-015 SHALL use radix-4 Booth recoding, one digit per cycle, 17 digits.
REQ-016 SHALL implement FSM IDLE, ITER, ACC, DONE.
REQ-017 IDLE: on i_start with cache miss, SHALL assert o_busy combinationally, latch operands/controls, clear partial sum, and go to ITER with digit counter 0.
REQ-018 ITER: SHALL add one Booth partial product per cycle; counter increments; after digit 16, SHALL go to ACC.
REQ-019 ACC: SHALL add the latched accumulator, write the 64-bit result plus operand/control tag to the cache, set cache-valid, and go to DONE.
REQ-020 DONE: SHALL drive o_busy=0 and o_rd from cache, then return to IDLE next cycle.
REQ-021 A cache hit SHALL be i_start & cache-valid & CACHE_EN & tag equal on {i_rm,i_rs,i_rn,i_rh,i_signed,i_accumulate}; i_high SHALL be excluded from the tag.
REQ-022 On a cache hit in IDLE/DONE, SHALL drive o_busy=0 and o_rd/o_nozero from cache in the same cycle (zero added latency).
REQ-023 A miss SHALL keep o_busy high for exactly 19 consecutive cycles (1 IDLE + 17 ITER + 1 ACC); o_rd SHALL be valid in the cycle o_busy first falls.
REQ-024 o_rd SHALL be 0 and o_busy 0 when i_start=0 in IDLE.
REQ-025 i_clear SHALL take priority over all events: FSM to IDLE and cache-valid cleared at the next edge; o_busy=0 from the next cycle.
REQ-026 A miss start SHALL invalidate the cache at latch time.
REQ-027 Changing operands while o_busy=1 is a protocol violation; latched values SHALL be used.
REQ-028 o_nozero SHALL equal OR of all 64 result bits.

Reset
REQ-029 While i_reset=0, SHALL force FSM=IDLE, counter=0, cache-valid=0, partial sum/cache=0, o_busy=0, o_rd=0, o_nozero=0, asynchronously.
REQ-030 Reset deassertion SHALL take effect at the next rising edge; an operation in progress is discarded.

Structure
REQ-031 FSM state encodings, digit count (17), and long-multiply opcode values SHALL reside in the shared package/include.
REQ-032 A combinational sub-module zap_booth_digit SHALL select the partial product (0, ±M, ±2M) from a 3-bit Booth window.

Verification
REQ-033 Unsigned: rm=0xFFFFFFFF, rs=0xFFFFFFFF, acc off, i_high=0 -> busy 19 cycles, o_rd=0x00000001; then i_high=1, same operands -> busy 0, o_rd=0xFFFFFFFE.
REQ-034 Signed: rm=0xFFFFFFFF, rs=1, acc {0x0,0x1} -> o_rd=0x00000000 for both halves, o_nozero=0.
REQ-035 Signed: rm=rs=0x80000000, acc off, i_high=1 -> o_rd=0x40000000, o_nozero=1; low half 0x00000000.
REQ-036 Wrap: unsigned 2×3, acc {0xFFFFFFFF,0xFFFFFFFF} -> low 0x00000005, high 0x00000000.
REQ-037 i_clear at ITER digit 5 -> o_busy=0 next cycle; re-request same operands -> full 19-cycle busy (cache invalid).
REQ-038 i_reset low mid-ITER -> o_busy=0, o_rd=0 immediately; after release, request recomputes correctly.
